sdram_arb_rr: RTL and testbench
===============================

SDRAM_ARB_RR -- requirements
Module: sdram_arb_rr

Interface
REQ-001 Parameter NUM_CH, default 4, number of requesting channels, range 2..8.
REQ-002 Parameter ADDR_W, default 25, word address width.
REQ-003 Parameter DATA_W, default 16, data width; BE_W = DATA_W/8.
REQ-004 Parameter HIPRI_CH, default 0, channel that bypasses round-robin; value NUM_CH disables it.
REQ-005 Parameter TIMEOUT_CYC, default 1024, watchdog limit in clk cycles.
REQ-006 The block SHALL have one clock, `clk`; reset `reset_n` is asynchronous and active-low.
REQ-007 Port ports: `clk` in 1, system clock. `reset_n` in 1, asynchronous active-low reset.
REQ-008 Channel-side ports:
- `ch_read` in NUM_CH, per-channel read request.
- `ch_write` in NUM_CH, per-channel write request.
- `ch_addr` in NUM_CH*ADDR_W, packed addresses.
- `ch_wrdata` in NUM_CH*DATA_W, packed write data.
- `ch_be` in NUM_CH*BE_W, packed byte enables.
- `ch_ack` out NUM_CH, one-hot completion pulse.
- `ch_rddata` out DATA_W, shared registered read data.
REQ-009 Bridge-side ports:
- `br_addr` out ADDR_W.
- `br_be` out BE_W.
- `br_read` out 1.
- `br_write` out 1.
- `br_wrdata` out DATA_W.
- `br_ack` in 1, completion from the SDRAM bridge.
- `br_rddata` in DATA_W.
REQ-010 Status ports: `busy` out 1, transaction in flight; `grant` out NUM_CH, one-hot owner.

Function
REQ-011 States SHALL be IDLE, ISSUE and DONE.
REQ-012 IDLE with no request: the block SHALL stay in IDLE.
REQ-013 IDLE with any request: the block SHALL latch the winner's address, data, byte enables and direction, set `grant`, and enter ISSUE on the next edge.
REQ-014 Winner selection:
- HIPRI_CH SHALL win whenever it requests.
- Otherwise the first requesting channel at or after `rr_ptr` SHALL win, searching upward and wrapping from NUM_CH-1 to 0.
REQ-015 ISSUE: `br_read` or `br_write` SHALL be held high, with the other bridge outputs stable, until `br_ack` is sampled high.
REQ-016 On `br_ack` the block SHALL capture `br_rddata` into `ch_rddata` and enter DONE.
REQ-017 DONE: the block SHALL pulse `ch_ack[grant]` for exactly 1 cycle, clear `grant`, and return to IDLE.
REQ-018 `rr_ptr` SHALL become (winner+1) mod NUM_CH after every non-HIPRI grant and SHALL stay unchanged after a HIPRI grant.
REQ-019 Latency SHALL be 1 cycle from request sampled to `br_read`/`br_write` high, and 1 cycle from `br_ack` to `ch_ack`.
REQ-020 A channel asserting both `ch_read` and `ch_write` SHALL be served as a write.
REQ-021 A requester deasserting while granted SHALL NOT abort the transaction; the ack pulse SHALL still be issued.
REQ-022 Requesters SHALL hold request, address and data until `ch_ack`; the arbiter SHALL use latched values only.
REQ-023 `ch_rddata` SHALL hold its value until the next read completes.
REQ-024 `busy` SHALL be high in ISSUE and DONE.
REQ-025 The IDLE-to-grant decision SHALL take at most one cycle; back-to-back transactions SHALL have 1 IDLE cycle between them.

Reset
REQ-026 On `reset_n` low, all outputs SHALL go to 0 immediately, asynchronously: `br_*`, `ch_ack`, `ch_rddata`, `grant` and `busy`.
REQ-027 On `reset_n` low, state SHALL become IDLE and `rr_ptr` SHALL become 0.
REQ-028 Reset mid-ISSUE SHALL drop the transaction without issuing `ch_ack`.

Configuration
REQ-029 With `SDRAM_ARB_TIMEOUT_EN` defined, a counter SHALL run in ISSUE and clear on state entry.
REQ-030 On reaching TIMEOUT_CYC without `br_ack`, the block SHALL deassert the bridge strobe, pulse `ch_ack` with `ch_rddata`=0, and set a sticky output `timeout_err` (1 bit, cleared only by reset).
REQ-031 Without `SDRAM_ARB_TIMEOUT_EN`, no counter and no `timeout_err` port SHALL exist, and ISSUE SHALL wait indefinitely.

Verification
REQ-032 Single read: ch1 reads addr 0x000123, `br_ack` 5 cycles later with `br_rddata`=0xBEEF -> `br_read` high 1 cycle after the request, `ch_ack`=0010 for 1 cycle, `ch_rddata`=0xBEEF.
REQ-033 Round-robin: ch1, ch2 and ch3 request continuously, HIPRI_CH=NUM_CH -> grant order 1,2,3,1; `rr_ptr` wraps 3->0.
REQ-034 Priority: ch0=HIPRI and ch2 request together, `rr_ptr`=2 -> ch0 served first, then ch2; `rr_ptr` unchanged after the ch0 grant.
REQ-035 Write precedence: ch3 asserts both read and write with `be`=10, data 0x1234 -> `br_write`=1, `br_be`=10, `br_wrdata`=0x1234, `br_read`=0.
REQ-036 Reset mid-ISSUE: `reset_n` pulled low 2 cycles into ISSUE -> all outputs 0 that cycle, no `ch_ack`; a fresh request after release is served from ch0 priority order.
REQ-037 Timeout (macro defined, TIMEOUT_CYC=16): `br_ack` never asserts -> strobe drops after 16 cycles, `ch_ack` pulses, `ch_rddata`=0, `timeout_err`=1 and stays 1.

Source files
------------

// File: rtl/sdram_arb_rr.sv
// Round-robin arbiter with one optional high-priority channel, fronting a single SDRAM bridge.
// Define SDRAM_ARB_TIMEOUT_EN to add an ISSUE watchdog and the sticky timeout_err output.
module sdram_arb_rr #(
  parameter int NUM_CH      = 4,
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 16,
  parameter int HIPRI_CH    = 0,
  parameter int TIMEOUT_CYC = 1024,
  localparam int BE_W       = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wrdata,
  input  logic [NUM_CH*BE_W-1:0]   ch_be,
  output logic [NUM_CH-1:0]        ch_ack,
  output logic [DATA_W-1:0]        ch_rddata,
  output logic [ADDR_W-1:0]        br_addr,
  output logic [BE_W-1:0]          br_be,
  output logic                     br_read,
  output logic                     br_write,
  output logic [DATA_W-1:0]        br_wrdata,
  input  logic                     br_ack,
  input  logic [DATA_W-1:0]        br_rddata,
  output logic                     busy,
  output logic [NUM_CH-1:0]        grant
`ifdef SDRAM_ARB_TIMEOUT_EN
  ,
  output logic                     timeout_err
`endif
);

  localparam int          PTR_W     = $clog2(NUM_CH);
  localparam int unsigned NCH       = NUM_CH;
  localparam bit          HIPRI_EN  = (HIPRI_CH < NUM_CH);
  localparam int          HIPRI_IDX = HIPRI_EN ? HIPRI_CH : 0;

  if (NUM_CH < 2 || NUM_CH > 8 || HIPRI_CH < 0 || HIPRI_CH > NUM_CH || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("sdram_arb_rr: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  winner;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] win_oh;
  logic [31:0]       idx;
  logic              any_req;
  logic              hipri_win;
  logic              found;
  logic              wr_lat;
  logic              tmo;

  // Winner search: high-priority channel first, else first requester at or after rr_ptr.
  always_comb begin
    req       = ch_read | ch_write;
    any_req   = |req;
    hipri_win = HIPRI_EN && req[HIPRI_IDX];
    winner    = '0;
    found     = 1'b0;
    idx       = '0;
    if (hipri_win) begin
      winner = PTR_W'(HIPRI_IDX);
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        idx = (32'(rr_ptr) + i) % NCH;
        if (!found && req[idx[PTR_W-1:0]]) begin
          winner = idx[PTR_W-1:0];
          found  = 1'b1;
        end
      end
    end
    win_oh         = '0;
    win_oh[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)       state_nxt = ISSUE;
      ISSUE:   if (br_ack || tmo) state_nxt = DONE;
      DONE:                       state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr    <= '0;
      grant     <= '0;
      br_addr   <= '0;
      br_be     <= '0;
      br_wrdata <= '0;
      wr_lat    <= 1'b0;
      ch_rddata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant     <= win_oh;
            br_addr   <= ch_addr[winner*ADDR_W +: ADDR_W];
            br_be     <= ch_be[winner*BE_W +: BE_W];
            br_wrdata <= ch_wrdata[winner*DATA_W +: DATA_W];
            wr_lat    <= ch_write[winner];
            if (!hipri_win)
              rr_ptr <= (winner == PTR_W'(NUM_CH - 1)) ? '0 : winner + 1'b1;
          end
        end
        ISSUE: begin
          if (br_ack) begin
            if (!wr_lat) ch_rddata <= br_rddata;
          end else if (tmo) begin
            ch_rddata <= '0;
          end
        end
        DONE:    grant <= '0;
        default: grant <= '0;
      endcase
    end
  end

  always_comb begin
    br_read  = (state == ISSUE) && !wr_lat;
    br_write = (state == ISSUE) && wr_lat;
    busy     = (state != IDLE);
    ch_ack   = (state == DONE) ? grant : '0;
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] tmo_cnt;

  always_comb begin
    tmo = (state == ISSUE) && !br_ack && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
  end

  // Counter restarts whenever the state changes, so it measures cycles spent in this ISSUE only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state != ISSUE || state_nxt != state) tmo_cnt <= '0;
      else                                      tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo) timeout_err <= 1'b1;
    end
  end
`else
  always_comb begin
    tmo = 1'b0;
  end
`endif

endmodule

// File: tb/tb_sdram_arb_rr.sv
// Directed and randomized bench for sdram_arb_rr against a transaction-level arbitration model.
module tb_sdram_arb_rr;

  localparam int NCH = 4;
  localparam int AW  = 25;
  localparam int DW  = 16;
  localparam int BW  = DW / 8;
  localparam int HP  = 0;

  logic              clk     = 1'b0;
  logic              reset_n = 1'b1;
  logic [NCH-1:0]    ch_read   = '0;
  logic [NCH-1:0]    ch_write  = '0;
  logic [NCH*AW-1:0] ch_addr   = '0;
  logic [NCH*DW-1:0] ch_wrdata = '0;
  logic [NCH*BW-1:0] ch_be     = '0;
  logic [NCH-1:0]    ch_ack;
  logic [DW-1:0]     ch_rddata;
  logic [AW-1:0]     br_addr;
  logic [BW-1:0]     br_be;
  logic              br_read;
  logic              br_write;
  logic [DW-1:0]     br_wrdata;
  logic              br_ack    = 1'b0;
  logic [DW-1:0]     br_rddata = '0;
  logic              busy;
  logic [NCH-1:0]    grant;
`ifdef SDRAM_ARB_TIMEOUT_EN
  logic              timeout_err;
`endif

  sdram_arb_rr #(
    .NUM_CH      (NCH),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .HIPRI_CH    (HP),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ch_read   (ch_read),
    .ch_write  (ch_write),
    .ch_addr   (ch_addr),
    .ch_wrdata (ch_wrdata),
    .ch_be     (ch_be),
    .ch_ack    (ch_ack),
    .ch_rddata (ch_rddata),
    .br_addr   (br_addr),
    .br_be     (br_be),
    .br_read   (br_read),
    .br_write  (br_write),
    .br_wrdata (br_wrdata),
    .br_ack    (br_ack),
    .br_rddata (br_rddata),
    .busy      (busy),
    .grant     (grant)
`ifdef SDRAM_ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: pointer, last read data, and what each requester is presenting.
  int             rr_m;
  logic [DW-1:0]  rd_m;
  logic [NCH-1:0] pend;
  logic [AW-1:0]  a_m [NCH];
  logic [DW-1:0]  d_m [NCH];
  logic [BW-1:0]  b_m [NCH];
  bit             r_m [NCH];
  bit             w_m [NCH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NCH-1:0] m, input int ptr);
    if (m[HP]) return HP;
    for (int k = 0; k < NCH; k++)
      if (m[(ptr + k) % NCH]) return (ptr + k) % NCH;
    return -1;
  endfunction

  function automatic logic [NCH-1:0] oh1(input int w);
    logic [NCH-1:0] v;
    v    = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  task automatic apply();
    for (int i = 0; i < NCH; i++) begin
      ch_read[i]               = pend[i] & r_m[i];
      ch_write[i]              = pend[i] & w_m[i];
      ch_addr[i*AW +: AW]      = a_m[i];
      ch_wrdata[i*DW +: DW]    = d_m[i];
      ch_be[i*BW +: BW]        = b_m[i];
    end
  endtask

  task automatic setch(input int i, input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] b);
    r_m[i]  = rd;
    w_m[i]  = wr;
    a_m[i]  = a;
    d_m[i]  = d;
    b_m[i]  = b;
    pend[i] = 1'b1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_br_addr", br_addr, 0);
    chk("rst_br_be", br_be, 0);
    chk("rst_br_read", br_read, 0);
    chk("rst_br_write", br_write, 0);
    chk("rst_br_wrdata", br_wrdata, 0);
    chk("rst_ch_ack", ch_ack, 0);
    chk("rst_ch_rddata", ch_rddata, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    pend   = '0;
    apply();
    br_ack = 1'b0;
    rr_m   = 0;
    rd_m   = '0;
    @(negedge clk);
    chk("rst_no_ack", ch_ack, 0);
    reset_n = 1'b1;
`ifdef SDRAM_ARB_TIMEOUT_EN
    chk("rst_timeout_err", timeout_err, 0);
`endif
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
  endtask

  // One transaction, entered at a negedge with the DUT idle and requests already applied.
  task automatic txn(input int want, input int delay, input bit keep, input bit drop,
                     input logic [DW-1:0] rdv);
    int            w;
    bit            wr;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [BW-1:0] eb;
    w  = (want >= 0) ? want : pick(pend, rr_m);
    wr = w_m[w];
    ea = a_m[w];
    ed = d_m[w];
    eb = b_m[w];
    @(negedge clk);
    chk("grant", grant, oh1(w));
    chk("br_read", br_read, !wr);
    chk("br_write", br_write, wr);
    chk("br_addr", br_addr, ea);
    chk("br_be", br_be, eb);
    chk("br_wrdata", br_wrdata, ed);
    chk("busy_issue", busy, 1);
    chk("no_ack_issue", ch_ack, 0);
    if (drop) begin
      pend[w] = 1'b0;
      a_m[w]  = ~a_m[w];
      apply();
    end
    for (int k = 0; k < delay; k++) begin
      @(negedge clk);
      chk("strobe_hold", {br_read, br_write}, {!wr, wr});
      chk("addr_hold", br_addr, ea);
      chk("no_early_ack", ch_ack, 0);
    end
    br_ack    = 1'b1;
    br_rddata = rdv;
    @(negedge clk);
    br_ack    = 1'b0;
    br_rddata = DW'($urandom);
    chk("ch_ack", ch_ack, oh1(w));
    chk("strobe_off", {br_read, br_write}, 0);
    chk("busy_done", busy, 1);
    if (!wr) rd_m = rdv;
    chk("ch_rddata", ch_rddata, rd_m);
    if (w != HP) rr_m = (w + 1) % NCH;
    if (!keep) pend[w] = 1'b0;
    apply();
    @(negedge clk);
    chk("idle_grant", grant, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ack", ch_ack, 0);
    chk("rddata_hold", ch_rddata, rd_m);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pend = '0;
    for (int i = 0; i < NCH; i++) begin
      r_m[i] = 1'b0; w_m[i] = 1'b0; a_m[i] = '0; d_m[i] = '0; b_m[i] = '0;
    end
    #2;
    do_reset();

    // Single read on ch1, bridge answers after several cycles.
    setch(1, 1'b1, 1'b0, 25'h000123, 16'h0000, 2'b11);
    apply();
    txn(1, 4, 1'b0, 1'b0, 16'hBEEF);
    chk("single_read_data", ch_rddata, 16'hBEEF);

    // Round-robin among ch1..ch3 with continuous requests.
    do_reset();
    setch(1, 1'b1, 1'b0, 25'h0000A1, 16'h1111, 2'b01);
    setch(2, 1'b1, 1'b0, 25'h0000A2, 16'h2222, 2'b10);
    setch(3, 1'b1, 1'b0, 25'h0000A3, 16'h3333, 2'b11);
    apply();
    txn(1, 1, 1'b1, 1'b0, 16'h0001);
    txn(2, 0, 1'b1, 1'b0, 16'h0002);
    txn(3, 2, 1'b1, 1'b0, 16'h0003);
    txn(1, 0, 1'b1, 1'b0, 16'h0004);
    pend = '0;
    apply();

    // Priority channel beats round-robin and leaves the pointer untouched.
    do_reset();
    setch(1, 1'b1, 1'b0, 25'h000011, 16'h0000, 2'b11);
    apply();
    txn(1, 0, 1'b0, 1'b0, 16'h5A5A);
    setch(0, 1'b1, 1'b0, 25'h000100, 16'h0000, 2'b11);
    setch(1, 1'b1, 1'b0, 25'h000101, 16'h0000, 2'b11);
    setch(2, 1'b0, 1'b1, 25'h000102, 16'hC0DE, 2'b01);
    apply();
    txn(0, 1, 1'b0, 1'b0, 16'h0A0A);
    txn(2, 0, 1'b0, 1'b0, 16'h0B0B);
    txn(1, 3, 1'b0, 1'b0, 16'h0C0C);

    // Read and write together is served as a write; bridge acks on the first ISSUE cycle.
    setch(3, 1'b1, 1'b1, 25'h1ABCDEF, 16'h1234, 2'b10);
    apply();
    txn(3, 0, 1'b0, 1'b0, 16'hFFFF);

    // Reset two cycles into ISSUE drops the transaction; pointer restarts at ch0.
    do_reset();
    setch(3, 1'b1, 1'b0, 25'h000333, 16'h0000, 2'b11);
    setch(2, 1'b1, 1'b0, 25'h000222, 16'h0000, 2'b11);
    pend[3] = 1'b0;
    apply();
    @(negedge clk);
    chk("mid_issue_strobe", br_read, 1);
    @(negedge clk);
    chk("mid_issue_grant", grant, oh1(2));
    do_reset();
    setch(1, 1'b1, 1'b0, 25'h000111, 16'h0000, 2'b11);
    setch(3, 1'b1, 1'b0, 25'h000333, 16'h0000, 2'b11);
    apply();
    txn(1, 1, 1'b0, 1'b0, 16'h7777);
    txn(3, 0, 1'b0, 1'b0, 16'h8888);

`ifdef SDRAM_ARB_TIMEOUT_EN
    do_reset();
    setch(0, 1'b1, 1'b0, 25'h000010, 16'h0000, 2'b11);
    apply();
    txn(0, 0, 1'b0, 1'b0, 16'hA5A5);
    setch(2, 1'b1, 1'b0, 25'h000020, 16'h0000, 2'b11);
    apply();
    @(negedge clk);
    for (int c = 1; c <= 16; c++) begin
      chk("tmo_strobe", br_read, 1);
      chk("tmo_err_low", timeout_err, 0);
      if (c < 16) @(negedge clk);
    end
    @(negedge clk);
    chk("tmo_strobe_off", br_read, 0);
    chk("tmo_ack", ch_ack, oh1(2));
    chk("tmo_rddata", ch_rddata, 0);
    chk("tmo_err", timeout_err, 1);
    rd_m    = '0;
    rr_m    = 3;
    pend[2] = 1'b0;
    apply();
    repeat (3) begin
      @(negedge clk);
      chk("tmo_err_sticky", timeout_err, 1);
    end
    setch(1, 1'b1, 1'b0, 25'h000030, 16'h0000, 2'b11);
    apply();
    txn(1, 2, 1'b0, 1'b0, 16'h4321);
    chk("tmo_err_after_ok", timeout_err, 1);
`endif

    // Randomized request mixes served until every requester has been acknowledged.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          case ($urandom_range(0, 2))
            0:       setch(i, 1'b1, 1'b0, AW'($urandom), DW'($urandom), BW'($urandom));
            1:       setch(i, 1'b0, 1'b1, AW'($urandom), DW'($urandom), BW'($urandom));
            default: setch(i, 1'b1, 1'b1, AW'($urandom), DW'($urandom), BW'($urandom));
          endcase
        end
      end
      if (pend == '0)
        setch(int'($urandom_range(0, NCH - 1)), 1'b1, 1'b0, AW'($urandom), DW'($urandom), BW'($urandom));
      apply();
      while (pend != '0)
        txn(-1, int'($urandom_range(0, 4)), 1'b0, ($urandom_range(0, 3) == 0), DW'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
